dsp_cmd_sequencer: RTL and testbench

//  Command-driven controller that operates one dsptop DSP48A1 slice.
//  - Accepts one operation per valid/ready handshake: opmode, A/B/D/C, carry-in.
//  - Drives the slice and holds its inputs stable until the internal pipeline settles.
//  - Loads the P register exactly once per operation, so accumulate opmodes (X/Z=P) add once.
//  - Returns P and carry-out over a valid/ready response channel. Sits between the system and the slice.

---
 rtl/dsp_cmd_sequencer.sv | 146 ++++++++++++++
 tb/tb_dsp_cmd_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dsp_cmd_sequencer.sv
// Command sequencer for one DSP48A1 slice: one op per handshake, P loaded once, result returned on rsp.
// Optional feature macro: DSP_SEQ_STATS_EN adds a 16-bit completed-operation counter output ops_done.
module dsp_cmd_sequencer #(
  parameter int DW      = 18,
  parameter int PW      = 48,
  parameter int OPW     = 8,
  parameter int LATENCY = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [OPW-1:0] cmd_opmode,
  input  logic [DW-1:0]  cmd_a,
  input  logic [DW-1:0]  cmd_b,
  input  logic [DW-1:0]  cmd_d,
  input  logic [PW-1:0]  cmd_c,
  input  logic           cmd_carryin,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [PW-1:0]  rsp_p,
  output logic           rsp_carryout,
  output logic [OPW-1:0] dsp_opmode,
  output logic [DW-1:0]  dsp_a,
  output logic [DW-1:0]  dsp_b,
  output logic [DW-1:0]  dsp_d,
  output logic [PW-1:0]  dsp_c,
  output logic           dsp_carryin,
  output logic           dsp_ce,
  output logic           dsp_cep,
  output logic           dsp_rst,
  input  logic [PW-1:0]  dsp_p,
  input  logic           dsp_carryout
`ifdef DSP_SEQ_STATS_EN
  ,
  output logic [15:0]    ops_done
`endif
);

  typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_EXEC, S_CAPT, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       w_cmd_hs, w_rsp_hs;

  logic [OPW-1:0] r_opmode;
  logic [DW-1:0]  r_a, r_b, r_d;
  logic [PW-1:0]  r_c;
  logic           r_carryin;
  logic [PW-1:0]  r_rsp_p;
  logic           r_rsp_co;

  assign w_cmd_hs = cmd_valid && (r_state == S_IDLE);
  assign w_rsp_hs = rsp_ready && (r_state == S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FLUSH;
      r_cnt   <= CNT_INIT;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The same down-counter times both the slice flush and the operand settle window.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_FLUSH: begin
        if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_IDLE: begin
        if (w_cmd_hs) begin
          w_state_nxt = S_EXEC;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      S_EXEC: begin
        if (r_cnt == 4'd0) w_state_nxt = S_CAPT;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_CAPT: w_state_nxt = S_RESP;
      S_RESP: if (w_rsp_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_FLUSH;
    endcase
  end

  // Operands only change on acceptance, so the slice sees no glitch between ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opmode  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_d       <= '0;
      r_c       <= '0;
      r_carryin <= 1'b0;
    end else if (w_cmd_hs) begin
      r_opmode  <= cmd_opmode;
      r_a       <= cmd_a;
      r_b       <= cmd_b;
      r_d       <= cmd_d;
      r_c       <= cmd_c;
      r_carryin <= cmd_carryin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_p  <= '0;
      r_rsp_co <= 1'b0;
    end else if (r_state == S_CAPT) begin
      r_rsp_p  <= dsp_p;
      r_rsp_co <= dsp_carryout;
    end
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign rsp_valid    = (r_state == S_RESP);
  assign rsp_p        = r_rsp_p;
  assign rsp_carryout = r_rsp_co;
  assign dsp_opmode   = r_opmode;
  assign dsp_a        = r_a;
  assign dsp_b        = r_b;
  assign dsp_d        = r_d;
  assign dsp_c        = r_c;
  assign dsp_carryin  = r_carryin;
  assign dsp_ce       = (r_state == S_EXEC);
  // CEP for exactly one cycle keeps accumulate opmodes from adding more than once.
  assign dsp_cep      = (r_state == S_EXEC) && (r_cnt == 4'd0);
  assign dsp_rst      = (r_state == S_FLUSH);

`ifdef DSP_SEQ_STATS_EN
  logic [15:0] r_ops_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ops_done <= '0;
    else if (w_rsp_hs) r_ops_done <= r_ops_done + 16'd1;
  end
  assign ops_done = r_ops_done;
`endif

endmodule

// File: tb/tb_dsp_cmd_sequencer.sv
// Scoreboard bench for dsp_cmd_sequencer with a simplified behavioural DSP48A1 slice model.
module tb_dsp_cmd_sequencer;
  localparam int DW = 18, PW = 48, OPW = 8, LATENCY = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0, cmd_ready;
  logic [OPW-1:0] cmd_opmode = '0;
  logic [DW-1:0]  cmd_a = '0, cmd_b = '0, cmd_d = '0;
  logic [PW-1:0]  cmd_c = '0;
  logic           cmd_carryin = 1'b0;
  logic           rsp_valid, rsp_ready = 1'b1;
  logic [PW-1:0]  rsp_p;
  logic           rsp_carryout;
  logic [OPW-1:0] dsp_opmode;
  logic [DW-1:0]  dsp_a, dsp_b, dsp_d;
  logic [PW-1:0]  dsp_c;
  logic           dsp_carryin, dsp_ce, dsp_cep, dsp_rst;
  logic [PW-1:0]  dsp_p;
  logic           dsp_carryout;
`ifdef DSP_SEQ_STATS_EN
  logic [15:0]    ops_done;
`endif

  dsp_cmd_sequencer #(.DW(DW), .PW(PW), .OPW(OPW), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opmode(cmd_opmode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_c(cmd_c), .cmd_carryin(cmd_carryin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p), .rsp_carryout(rsp_carryout),
    .dsp_opmode(dsp_opmode), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
    .dsp_carryin(dsp_carryin), .dsp_ce(dsp_ce), .dsp_cep(dsp_cep), .dsp_rst(dsp_rst),
    .dsp_p(dsp_p), .dsp_carryout(dsp_carryout)
`ifdef DSP_SEQ_STATS_EN
    , .ops_done(ops_done)
`endif
  );

  always #5 clk = ~clk;

  // Slice model: one input register stage on CE, P/carry register on CEP.
  logic [OPW-1:0] m_op;
  logic [DW-1:0]  m_a, m_b, m_d;
  logic [PW-1:0]  m_c;
  logic           m_cin;
  logic [PW-1:0]  m_p;
  logic           m_co;
  logic [DW-1:0]  m_pre;
  logic [PW:0]    m_x, m_z, m_sum;

  always_comb begin
    m_pre = m_op[4] ? (m_op[6] ? m_d - m_b : m_d + m_b) : m_b;
    case (m_op[1:0])
      2'd1:    m_x = (PW+1)'(m_pre * m_a);
      2'd2:    m_x = {1'b0, m_p};
      2'd3:    m_x = (PW+1)'({m_d[11:0], m_a, m_b});
      default: m_x = '0;
    endcase
    case (m_op[3:2])
      2'd2:    m_z = {1'b0, m_p};
      2'd3:    m_z = {1'b0, m_c};
      default: m_z = '0;
    endcase
    m_sum = m_z + m_x + (PW+1)'(m_cin);
  end

  always @(posedge clk) begin
    if (dsp_rst) begin
      m_op <= '0; m_a <= '0; m_b <= '0; m_d <= '0; m_c <= '0; m_cin <= 1'b0;
      m_p <= '0; m_co <= 1'b0;
    end else begin
      if (dsp_ce) begin
        m_op <= dsp_opmode; m_a <= dsp_a; m_b <= dsp_b; m_d <= dsp_d;
        m_c <= dsp_c; m_cin <= dsp_carryin;
      end
      if (dsp_cep) {m_co, m_p} <= m_sum;
    end
  end
  assign dsp_p        = m_p;
  assign dsp_carryout = m_co;

  int checks = 0, failures = 0, cep_seen = 0, n_rsp = 0;
  logic [PW:0] expq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n && dsp_cep) cep_seen <= cep_seen + 1;

  // Monitor: the handshake completes on the next posedge; rsp_ready only changes just after posedges.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      logic [PW:0] e;
      n_rsp <= n_rsp + 1;
      if (expq.size() == 0) chk("unexpected_rsp", 64'(rsp_p), 64'hDEAD);
      else begin
        e = expq.pop_front();
        chk("rsp_p", 64'(rsp_p), 64'(e[PW-1:0]));
        chk("rsp_carryout", 64'(rsp_carryout), 64'(e[PW]));
      end
    end
  end

  task automatic send(input logic [7:0] op, input logic [DW-1:0] a, b, d, input logic [PW-1:0] c,
                      input logic cin, input logic [PW-1:0] ep, input logic eco,
                      input bit push, input bit meas);
    int n, cep0;
    @(negedge clk);
    cmd_opmode = op; cmd_a = a; cmd_b = b; cmd_d = d; cmd_c = c; cmd_carryin = cin;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (push) expq.push_back({eco, ep});
    cep0 = cep_seen;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (meas) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 30);
      chk("rsp_latency", 64'(n - 1), 64'(LATENCY + 1));
      chk("cep_pulses", 64'(cep_seen - cep0), 64'd1);
    end
  endtask

  initial begin
    int n;
    bit ok;
    #1;
    chk("rst_dsp_rst", 64'(dsp_rst), 64'd1);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_dsp_ce", 64'({dsp_ce, dsp_cep}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Op dropped by a mid-EXEC reset.
    send(8'h01, 18'd5, 18'd5, 18'd0, 48'd0, 1'b0, 48'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    n_rsp = 0;
    #1;
    chk("midrst_dsp_rst", 64'(dsp_rst), 64'd1);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("midrst_dsp_ce", 64'(dsp_ce), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 30);
    chk("flush_cycles", 64'(n), 64'(LATENCY));

    send(8'h01, 18'd15, 18'd12, 18'd0,  48'd0,  1'b0, 48'd180, 1'b0, 1'b1, 1'b1);
    send(8'h1D, 18'd15, 18'd12, 18'd20, 48'd32, 1'b0, 48'd512, 1'b0, 1'b1, 1'b1);
    send(8'h01, 18'd15, 18'd12, 18'd0,  48'd0,  1'b0, 48'd180, 1'b0, 1'b1, 1'b1);
    send(8'h0E, 18'd0,  18'd0,  18'd0,  48'd32, 1'b0, 48'd212, 1'b0, 1'b1, 1'b1);
    send(8'h0E, 18'd0,  18'd0,  18'd0,  48'd32, 1'b0, 48'd244, 1'b0, 1'b1, 1'b1);
    send(8'h0C, 18'd0,  18'd0,  18'd0,  48'hFFFF_FFFF_FFFF, 1'b1, 48'd0, 1'b1, 1'b1, 1'b1);

    // Backpressure: hold rsp_ready low, offer a competing command meanwhile.
    @(posedge clk); #1 rsp_ready = 1'b0;
    send(8'h01, 18'd7, 18'd3, 18'd0, 48'd0, 1'b0, 48'd21, 1'b0, 1'b1, 1'b1);
    ok = 1'b1;
    cmd_opmode = 8'h01; cmd_a = 18'd9; cmd_b = 18'd9; cmd_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_p !== 48'd21 || cmd_ready) ok = 1'b0;
    end
    chk("bp_hold", 64'(ok), 64'd1);
    cmd_valid = 1'b0;
    @(posedge clk); #1 rsp_ready = 1'b1;

    n = 0;
    while ((expq.size() != 0 || rsp_valid) && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(expq.size()), 64'd0);
    chk("rsp_count", 64'(n_rsp), 64'd7);
`ifdef DSP_SEQ_STATS_EN
    chk("ops_done", 64'(ops_done), 64'd7);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
